// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver (uart_rx_cfg) and the
// transmitter that will sit beside it.
//   uart_state_e : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_*        : parity-mode constants for the PARITY parameter
//   parity_ok()  : checks a received parity bit against the data bits
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // data_xor is the XOR of all data bits. Odd mode wants an odd total
    // count of ones across data plus parity, even mode an even count.
    function automatic logic parity_ok(input int mode, input logic data_xor,
                                       input logic par_bit);
        logic ones_odd;
        ones_odd = data_xor ^ par_bit;
        case (mode)
            PAR_ODD:  return ones_odd;
            PAR_EVEN: return !ones_odd;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler -- per-bit majority sampler for the UART receiver.
// Counts CLK_DIV cycles per bit and how many of them saw the line high.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : count this cycle (a frame is in progress or starting)
//   rxs      : synchronised serial line
//   bit_done : last cycle of the current bit period
//   bit_val  : decided bit value, valid while bit_done is high
module uart_bit_sampler #(
    parameter int CLK_DIV = 286
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rxs,
    output logic bit_done,
    output logic bit_val
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int ONES_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(CLK_DIV / 2);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [ONES_W-1:0] ones_sum;

    always_comb begin
        // The sample taken in the final cycle is included in the decision,
        // so the vote always covers exactly CLK_DIV samples.
        ones_sum = ones_q + {{(ONES_W-1){1'b0}}, rxs};
        bit_done = en && (cnt_q == CNT_LAST);
        bit_val  = (ones_sum > ONES_HALF);
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        if (bit_done) begin
            cnt_d  = '0;
            ones_d = '0;
        end else if (en) begin
            cnt_d  = cnt_q + 1'b1;
            ones_d = ones_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver with a one-entry holding register.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   rx         : asynchronous serial line, idles high
//   data       : received word, LSB-aligned, upper bits zero
//   data_valid : holding register full
//   data_ready : consumer takes data while data_valid is high
//   frame_err  : one-cycle pulse, a stop bit sampled 0
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, good frame dropped because register full
//   break_det  : one-cycle pulse, whole frame through first stop sampled 0
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 286,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       break_det
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);

    logic        rx_meta_q, rxs_q;
    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        xor_q, xor_d;
    logic        zero_q, zero_d;
    logic        stop_err_q, stop_err_d;
    logic        par_err_q, par_err_d;
    logic        brk_wait_q, brk_wait_d;
    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;
    logic        break_q, break_d;

    logic start_det, smp_en, bit_done, bit_val;
    logic last_stop, stop_bad, brk_now;

    // Flops reset high so releasing reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // After a break the line is still low; wait for it to return high before
    // arming start detection, otherwise the tail of the break would be taken
    // for a new frame.
    assign start_det = (state_q == ST_IDLE) && !rxs_q && !brk_wait_q;
    // The detection cycle is already cycle 0 of the start bit.
    assign smp_en    = (state_q != ST_IDLE) || start_det;

    uart_bit_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .en       (smp_en),
        .rxs      (rxs_q),
        .bit_done (bit_done),
        .bit_val  (bit_val)
    );

    assign last_stop = (STOP_BITS == 1) || stop_idx_q;
    assign stop_bad  = stop_err_q || !bit_val;
    // Only the first stop bit takes part in break detection.
    assign brk_now   = stop_idx_q ? zero_q : (zero_q && !bit_val);

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        xor_d        = xor_q;
        zero_d       = zero_q;
        stop_err_d   = stop_err_q;
        par_err_d    = par_err_q;
        brk_wait_d   = brk_wait_q;
        data_d       = data_q;
        dv_d         = dv_q && !data_ready;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        break_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxs_q) begin
                    brk_wait_d = 1'b0;
                end
                if (start_det) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    xor_d      = 1'b0;
                    zero_d     = 1'b1;
                    stop_err_d = 1'b0;
                    par_err_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d[bit_idx_q] = bit_val;
                    xor_d  = xor_q ^ bit_val;
                    zero_d = zero_q && !bit_val;
                    if (bit_idx_q == LAST_DATA) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_err_d = !parity_ok(PARITY, xor_q, bit_val);
                    zero_d    = zero_q && !bit_val;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!last_stop) begin
                        stop_idx_d = 1'b1;
                        stop_err_d = stop_bad;
                        zero_d     = brk_now;
                    end else begin
                        state_d = ST_IDLE;
                        if (brk_now) begin
                            break_d    = 1'b1;
                            brk_wait_d = 1'b1;
                        end else if (stop_bad) begin
                            frame_err_d = 1'b1;
                        end else if (par_err_q) begin
                            parity_err_d = 1'b1;
                        end else if (!dv_q || data_ready) begin
                            data_d = shift_q;
                            dv_d   = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            xor_q        <= 1'b0;
            zero_q       <= 1'b0;
            stop_err_q   <= 1'b0;
            par_err_q    <= 1'b0;
            brk_wait_q   <= 1'b0;
            data_q       <= 8'h00;
            dv_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            xor_q        <= xor_d;
            zero_q       <= zero_d;
            stop_err_q   <= stop_err_d;
            par_err_q    <= par_err_d;
            brk_wait_q   <= brk_wait_d;
            data_q       <= data_d;
            dv_q         <= dv_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: unit 0 is 8-N-1, unit 1 is 8-E-1, both CLK_DIV=16.
module tb_uart_rx_cfg;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] rx_l  = 2'b11;
    logic [1:0] rdy_l = 2'b00;
    logic [1:0] dv_l, fe_l, pe_l, ov_l, bd_l;
    logic [7:0] data_a, data_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_DIV(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .data(data_a), .data_valid(dv_l[0]),
        .data_ready(rdy_l[0]), .frame_err(fe_l[0]), .parity_err(pe_l[0]),
        .overrun(ov_l[0]), .break_det(bd_l[0])
    );

    uart_rx_cfg #(.CLK_DIV(D), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .data(data_p), .data_valid(dv_l[1]),
        .data_ready(rdy_l[1]), .frame_err(fe_l[1]), .parity_err(pe_l[1]),
        .overrun(ov_l[1]), .break_det(bd_l[1])
    );

    // Event monitor, sampled on the falling edge.
    int ncyc = 0;
    int n_rise[2], n_hi[2], n_fe[2], n_pe[2], n_ov[2], n_bd[2], rise_cyc[2], ev_cyc[2];
    int n_unstable = 0;
    logic [1:0] prev_dv = 2'b00;
    logic [1:0] prev_rdy = 2'b00;
    logic [7:0] prev_data [2];

    function automatic logic [7:0] dat(input int u);
        return (u == 0) ? data_a : data_p;
    endfunction

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (dv_l[u]) n_hi[u]++;
            if (dv_l[u] && !prev_dv[u]) begin n_rise[u]++; rise_cyc[u] = ncyc; end
            if (fe_l[u]) begin n_fe[u]++; ev_cyc[u] = ncyc; end
            if (pe_l[u]) begin n_pe[u]++; ev_cyc[u] = ncyc; end
            if (ov_l[u]) begin n_ov[u]++; ev_cyc[u] = ncyc; end
            if (bd_l[u]) begin n_bd[u]++; ev_cyc[u] = ncyc; end
            if (prev_dv[u] && dv_l[u] && !prev_rdy[u] && dat(u) != prev_data[u]) n_unstable++;
            prev_dv[u]   = dv_l[u];
            prev_rdy[u]  = rdy_l[u];
            prev_data[u] = dat(u);
        end
    end

    int s_rise, s_hi, s_fe, s_pe, s_ov, s_bd;

    task automatic snap(input int u);
        s_rise = n_rise[u]; s_hi = n_hi[u]; s_fe = n_fe[u];
        s_pe = n_pe[u]; s_ov = n_ov[u]; s_bd = n_bd[u];
    endtask

    // Frame as a bit list, index 0 first on the wire: start, data LSB first,
    // optional parity, one stop bit.
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input int par_mode,
                                             input logic par_flip, input logic stop_val);
        logic [15:0] f;
        int ones;
        int pos;
        logic p;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        pos = 9;
        if (par_mode != 0) begin
            ones = $countones(d);
            if (par_mode == 2) p = ((ones % 2) == 1);
            else               p = ((ones % 2) == 0);
            f[9] = p ^ par_flip;
            pos = 10;
        end
        f[pos] = stop_val;
        return f;
    endfunction

    // Each bit is held D cycles. The result appears after 2 synchroniser
    // edges plus the 1-cycle decision: 3 falling edges after end_cyc.
    task automatic drive_bits(input int u, input logic [15:0] bits, input int n,
                              output int end_cyc);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            rx_l[u] = bits[i];
            repeat (D) begin @(posedge clk); #1; end
        end
        rx_l[u] = 1'b1;
        end_cyc = ncyc;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dv_l !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", dv_l); end
        checks++;
        if (data_a !== 8'h00 || data_p !== 8'h00) begin
            errors++; $display("FAIL reset_data got %02h/%02h want 00/00", data_a, data_p);
        end
        checks++;
        if ((fe_l | pe_l | ov_l | bd_l) !== 2'b00) begin
            errors++; $display("FAIL reset_pulses got %b want 00", fe_l | pe_l | ov_l | bd_l);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dv_l !== 2'b00) begin errors++; $display("FAIL reset_idle_valid got %b want 00", dv_l); end
        $display("reset done");
    endtask

    task automatic test_basic();
        int e;
        rdy_l[0] = 1'b1;
        snap(0);
        drive_bits(0, mk_frame(8'h5A, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (n_rise[0] - s_rise !== 1) begin errors++; $display("FAIL basic_rise got %0d want 1", n_rise[0] - s_rise); end
        checks++;
        if (rise_cyc[0] !== e + 3) begin errors++; $display("FAIL basic_latency got %0d want %0d", rise_cyc[0], e + 3); end
        checks++;
        if (n_hi[0] - s_hi !== 1) begin errors++; $display("FAIL basic_valid_width got %0d want 1", n_hi[0] - s_hi); end
        checks++;
        if (data_a !== 8'h5A) begin errors++; $display("FAIL basic_data got %02h want 5a", data_a); end
        checks++;
        if (n_fe[0] + n_pe[0] + n_ov[0] + n_bd[0] - s_fe - s_pe - s_ov - s_bd !== 0) begin
            errors++; $display("FAIL basic_pulses got nonzero want 0");
        end
        $display("basic frame data %02h", data_a);
    endtask

    task automatic test_false_start();
        int e;
        snap(0);
        @(posedge clk); #1;
        rx_l[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rx_l[0] = 1'b1;
        repeat (2 * D) @(negedge clk);
        checks++;
        if (n_rise[0] - s_rise !== 0) begin errors++; $display("FAIL glitch_rise got %0d want 0", n_rise[0] - s_rise); end
        checks++;
        if (n_fe[0] + n_pe[0] + n_ov[0] + n_bd[0] - s_fe - s_pe - s_ov - s_bd !== 0) begin
            errors++; $display("FAIL glitch_pulses got nonzero want 0");
        end
        snap(0);
        drive_bits(0, mk_frame(8'hC3, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (data_a !== 8'hC3) begin errors++; $display("FAIL glitch_next_data got %02h want c3", data_a); end
        checks++;
        if (rise_cyc[0] !== e + 3) begin errors++; $display("FAIL glitch_next_latency got %0d want %0d", rise_cyc[0], e + 3); end
        $display("glitch then frame data %02h", data_a);
    endtask

    task automatic test_parity();
        int e;
        rdy_l[1] = 1'b1;
        snap(1);
        drive_bits(1, mk_frame(8'h07, 2, 1'b1, 1'b1), 11, e);
        repeat (6) @(negedge clk);
        checks++;
        if (n_pe[1] - s_pe !== 1) begin errors++; $display("FAIL parity_err_count got %0d want 1", n_pe[1] - s_pe); end
        checks++;
        if (ev_cyc[1] !== e + 3) begin errors++; $display("FAIL parity_err_cycle got %0d want %0d", ev_cyc[1], e + 3); end
        checks++;
        if (n_rise[1] - s_rise !== 0) begin errors++; $display("FAIL parity_err_valid got %0d want 0", n_rise[1] - s_rise); end
        snap(1);
        drive_bits(1, mk_frame(8'h07, 2, 1'b0, 1'b1), 11, e);
        repeat (6) @(negedge clk);
        checks++;
        if (data_p !== 8'h07) begin errors++; $display("FAIL parity_ok_data got %02h want 07", data_p); end
        checks++;
        if (rise_cyc[1] !== e + 3) begin errors++; $display("FAIL parity_ok_latency got %0d want %0d", rise_cyc[1], e + 3); end
        checks++;
        if (n_pe[1] - s_pe !== 0) begin errors++; $display("FAIL parity_ok_pulse got %0d want 0", n_pe[1] - s_pe); end
        $display("parity frames done data %02h", data_p);
    endtask

    task automatic test_frame_err();
        int e;
        snap(0);
        drive_bits(0, mk_frame(8'h11, 0, 1'b0, 1'b0), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (n_fe[0] - s_fe !== 1) begin errors++; $display("FAIL frame_err_count got %0d want 1", n_fe[0] - s_fe); end
        checks++;
        if (ev_cyc[0] !== e + 3) begin errors++; $display("FAIL frame_err_cycle got %0d want %0d", ev_cyc[0], e + 3); end
        checks++;
        if (n_rise[0] - s_rise + n_bd[0] - s_bd !== 0) begin errors++; $display("FAIL frame_err_other got nonzero want 0"); end
        snap(0);
        drive_bits(0, 16'h0000, 12, e);
        repeat (3 * D) @(negedge clk);
        checks++;
        if (n_bd[0] - s_bd !== 1) begin errors++; $display("FAIL break_count got %0d want 1", n_bd[0] - s_bd); end
        checks++;
        if (n_fe[0] - s_fe + n_pe[0] - s_pe + n_ov[0] - s_ov !== 0) begin errors++; $display("FAIL break_other_pulses got nonzero want 0"); end
        checks++;
        if (n_rise[0] - s_rise !== 0) begin errors++; $display("FAIL break_valid got %0d want 0", n_rise[0] - s_rise); end
        $display("frame error and break done");
    endtask

    task automatic test_overrun();
        int e;
        rdy_l[0] = 1'b0;
        snap(0);
        drive_bits(0, mk_frame(8'h01, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (data_a !== 8'h01 || dv_l[0] !== 1'b1) begin
            errors++; $display("FAIL overrun_first got %02h/%b want 01/1", data_a, dv_l[0]);
        end
        drive_bits(0, mk_frame(8'h02, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (n_ov[0] - s_ov !== 1) begin errors++; $display("FAIL overrun_count got %0d want 1", n_ov[0] - s_ov); end
        checks++;
        if (ev_cyc[0] !== e + 3) begin errors++; $display("FAIL overrun_cycle got %0d want %0d", ev_cyc[0], e + 3); end
        checks++;
        if (data_a !== 8'h01 || dv_l[0] !== 1'b1) begin
            errors++; $display("FAIL overrun_held got %02h/%b want 01/1", data_a, dv_l[0]);
        end
        @(posedge clk); #1;
        rdy_l[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (dv_l[0] !== 1'b1) begin errors++; $display("FAIL drain_early got %b want 1", dv_l[0]); end
        @(negedge clk);
        checks++;
        if (dv_l[0] !== 1'b0) begin errors++; $display("FAIL drain_clear got %b want 0", dv_l[0]); end
        $display("overrun sequence done");
    endtask

    task automatic test_reset_mid();
        int e;
        logic [15:0] f;
        rdy_l[0] = 1'b0;
        drive_bits(0, mk_frame(8'h3C, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (dv_l[0] !== 1'b1 || data_a !== 8'h3C) begin
            errors++; $display("FAIL rstmid_pre got %02h/%b want 3c/1", data_a, dv_l[0]);
        end
        f = mk_frame(8'hF0, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rx_l[0] = f[i];
            repeat (D) begin @(posedge clk); #1; end
        end
        rx_l[0] = f[4];
        repeat (D / 2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        rx_l[0] = 1'b1;
        #1;
        checks++;
        if (dv_l[0] !== 1'b0 || data_a !== 8'h00) begin
            errors++; $display("FAIL rstmid_clear got %02h/%b want 00/0", data_a, dv_l[0]);
        end
        checks++;
        if ((fe_l | pe_l | ov_l | bd_l) !== 2'b00) begin errors++; $display("FAIL rstmid_pulses got nonzero want 0"); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        snap(0);
        repeat (2 * D) @(negedge clk);
        checks++;
        if (n_rise[0] - s_rise + n_fe[0] - s_fe + n_bd[0] - s_bd !== 0) begin
            errors++; $display("FAIL rstmid_quiet got nonzero want 0");
        end
        rdy_l[0] = 1'b1;
        drive_bits(0, mk_frame(8'hA5, 0, 1'b0, 1'b1), 10, e);
        repeat (6) @(negedge clk);
        checks++;
        if (data_a !== 8'hA5) begin errors++; $display("FAIL rstmid_next_data got %02h want a5", data_a); end
        checks++;
        if (rise_cyc[0] !== e + 3) begin errors++; $display("FAIL rstmid_next_latency got %0d want %0d", rise_cyc[0], e + 3); end
        $display("reset mid-frame done data %02h", data_a);
    endtask

    // Reference: each frame yields break, frame error, parity error or a
    // good word; a good word enters the one-entry buffer when it is empty or
    // being read, else it is dropped with an overrun.
    task automatic test_random();
        logic       exp_v [2];
        logic [7:0] exp_d [2];
        int e, u, kind, n;
        logic r, stop_v, flip, is_brk, is_fe, is_pe, load, ovr;
        logic [7:0] d;
        // unit 0 last loaded A5; unit 1 was cleared by the mid-frame reset
        exp_d[0] = 8'hA5;
        exp_d[1] = 8'h00;
        rdy_l = 2'b11;
        repeat (4) @(negedge clk);
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        for (int t = 0; t < 24; t++) begin
            u      = $urandom_range(0, 1);
            r      = 1'($urandom_range(0, 1));
            d      = 8'($urandom);
            kind   = $urandom_range(0, 5);
            if (t == 5) d = 8'h00;
            stop_v = (kind != 0);
            flip   = (u == 1) && (kind == 1);
            n      = (u == 1) ? 11 : 10;
            rdy_l[u] = r;
            if (exp_v[u] && r) exp_v[u] = 1'b0;
            is_brk = (d == 8'h00) && !stop_v && !flip;
            is_fe  = !is_brk && !stop_v;
            is_pe  = !is_brk && !is_fe && flip;
            load   = !is_brk && !is_fe && !is_pe && (!exp_v[u] || r);
            ovr    = !is_brk && !is_fe && !is_pe && !load;
            if (load) begin exp_d[u] = d; exp_v[u] = !r; end
            snap(u);
            drive_bits(u, mk_frame(d, (u == 1) ? 2 : 0, flip, stop_v), n, e);
            repeat (6) @(negedge clk);
            $display("frame %0d unit %0d data %02h stop %0b flip %0b ready %0b got %02h/%b",
                     t, u, d, stop_v, flip, r, dat(u), dv_l[u]);
            checks++;
            if (n_rise[u] - s_rise !== int'(load)) begin errors++; $display("FAIL rnd_rise t=%0d got %0d want %0d", t, n_rise[u] - s_rise, load); end
            checks++;
            if (n_ov[u] - s_ov !== int'(ovr)) begin errors++; $display("FAIL rnd_overrun t=%0d got %0d want %0d", t, n_ov[u] - s_ov, ovr); end
            checks++;
            if (n_fe[u] - s_fe !== int'(is_fe)) begin errors++; $display("FAIL rnd_frame_err t=%0d got %0d want %0d", t, n_fe[u] - s_fe, is_fe); end
            checks++;
            if (n_pe[u] - s_pe !== int'(is_pe)) begin errors++; $display("FAIL rnd_parity_err t=%0d got %0d want %0d", t, n_pe[u] - s_pe, is_pe); end
            checks++;
            if (n_bd[u] - s_bd !== int'(is_brk)) begin errors++; $display("FAIL rnd_break t=%0d got %0d want %0d", t, n_bd[u] - s_bd, is_brk); end
            checks++;
            if (dv_l[u] !== exp_v[u]) begin errors++; $display("FAIL rnd_valid t=%0d got %b want %b", t, dv_l[u], exp_v[u]); end
            checks++;
            if (dat(u) !== exp_d[u]) begin errors++; $display("FAIL rnd_data t=%0d got %02h want %02h", t, dat(u), exp_d[u]); end
        end
        checks++;
        if (n_unstable !== 0) begin errors++; $display("FAIL data_stable got %0d changes want 0", n_unstable); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_DIV, default 286, clk cycles per bit (115200 baud at 33 MHz); legal range 8..4095.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-008 SHALL have port data, output, 8, received byte, LSB-aligned; unused upper bits are 0.
REQ-009 SHALL have port data_valid, output, 1, holding register full.
REQ-010 SHALL have port data_ready, input, 1, consumer accepts data.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit samples 0.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a good frame arrives while data_valid=1.
REQ-014 SHALL have port break_det, output, 1, one-cycle pulse when start, data, parity and first stop bit all sample 0.

Function
REQ-015 SHALL pass rx through a two-flop synchroniser; all further logic uses the synchronised value rxs.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when rxs=0; the bit-cycle counter starts at 0 in that cycle.
REQ-017 SHALL sample each bit by counting the rxs=1 cycles over CLK_DIV cycles.
- Bit value = 1 iff count > CLK_DIV/2 (integer division).
- The count clears at each bit boundary.
REQ-018 SHALL return to IDLE when the START bit samples 1 (false start): no output, no pulse.
REQ-019 SHALL shift DATA bits LSB first and leave DATA after DATA_BITS bits.
- Next state: PARITY if PARITY!=0, else STOP.
REQ-020 SHALL check parity over the data bits in PARITY state.
- Odd mode: data plus parity bit contains an odd number of 1s.
- Even mode: an even number of 1s.
REQ-021 SHALL evaluate STOP_BITS stop bits, then return to IDLE.
- The next start can be detected in the cycle after the last stop sample.
REQ-022 SHALL decide the frame outcome in the cycle after the final stop sample, in priority order:
- break_det;
- else frame_err;
- else parity_err;
- else good frame.
REQ-023 SHALL not load an errored or break frame into data.
REQ-024 SHALL load a good frame into data and set data_valid=1 when data_valid=0 or data_ready=1 in that cycle.
REQ-025 SHALL keep the old data, keep data_valid=1 and pulse overrun when a good frame completes while data_valid=1 and data_ready=0.
REQ-026 SHALL clear data_valid on the cycle after data_valid=1 and data_ready=1 unless a new frame loads in the same cycle.
REQ-027 SHALL hold data stable while data_valid=1; data_ready while data_valid=0 has no effect.
REQ-028 SHALL use a bit counter wide enough for CLK_DIV-1 and a ones counter wide enough for CLK_DIV; both wrap only at bit boundaries.
REQ-029 SHALL keep latency from the end of the final stop bit to data_valid at exactly 1 cycle.

Reset
REQ-030 SHALL on rst=1 immediately set state=IDLE, counters=0, data=8'h00, data_valid=0 and all error pulses=0.
REQ-031 SHALL reset the synchroniser flops to 1 so reset does not fake a start bit.
REQ-032 SHALL, on reset mid-frame, discard the partial frame with no pulse; reception resumes at the next falling edge after release.

Structure
REQ-033 SHALL take the state encoding and the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) from shared package uart_pkg; the future uart_tx_cfg reuses this package.
REQ-034 SHALL instantiate one sub-module, uart_bit_sampler: the bit-cycle counter plus ones counter, with outputs bit_done and bit_val.

Verification
REQ-035 SHALL verify, with CLK_DIV=16, 8-N-1: frame 0x5A with data_ready=1 -> data=0x5A, data_valid high 1 cycle, 1 cycle after the stop bit.
REQ-036 SHALL verify a 4-cycle low glitch on an idle line -> false start, no outputs, the following frame 0xC3 received correctly.
REQ-037 SHALL verify, with PARITY=2, frame 0x07 with parity bit 0 -> parity_err pulse, data_valid stays 0; with parity bit 1 -> data=0x07.
REQ-038 SHALL verify frame 0x11 with stop bit 0 -> frame_err; rx low for 12 bit times -> break_det only.
REQ-039 SHALL verify data_ready=0, frames 0x01 then 0x02 -> data=0x01 held, overrun pulse at the 0x02 frame end.
REQ-040 SHALL verify rst asserted at DATA bit 3 -> outputs clear immediately; the next frame 0xA5 after release is received.
